bus_sram_slave: RTL



---
 rtl/bus_sram_slave.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/bus_sram_slave.sv
// bus_sram_slave: single-port word-addressed SRAM slave on the team bus.
// A request (i_trans = NONSEQ) is latched in IDLE. The slave holds o_resp at PENDING for
// WAIT_CYCLES cycles, then presents SUCCESS / ERROR_1 / ERROR_2 for exactly one cycle.
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   i_trans    transfer code (0 = IDLE, 1 = NONSEQ)
//   i_write    1 = write, 0 = read
//   i_addr     byte address
//   i_wdata    write data
//   o_resp     response code (0 PENDING, 1 SUCCESS, 2 ERROR_1 range, 3 ERROR_2 misaligned)
//   o_rdata    read data, non-zero only on a SUCCESS read response
//   o_busy     request in flight (BUSY or RESP)
//   o_err_cnt  saturating count of error responses
module bus_sram_slave #(
  parameter int unsigned            ADDR_WIDTH  = 32,
  parameter int unsigned            DATA_WIDTH  = 32,
  parameter int unsigned            DEPTH       = 256,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR   = 32'h0000_1000,
  parameter int unsigned            WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_trans,
  input  logic                  i_write,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [1:0]            o_resp,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_busy,
  output logic [7:0]            o_err_cnt
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  localparam logic TRANS_NONSEQ = 1'b1;

  localparam logic [1:0] RESP_PENDING = 2'd0;
  localparam logic [1:0] RESP_SUCCESS = 2'd1;
  localparam logic [1:0] RESP_ERROR_1 = 2'd2;
  localparam logic [1:0] RESP_ERROR_2 = 2'd3;

  // Counter preload so that the response appears WAIT_CYCLES edges after the request edge.
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    write_q, write_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [1:0]              resp_q, resp_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    busy_q, busy_d;
  logic [7:0]              err_cnt_q, err_cnt_d;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  // With zero wait states RESP is entered on the request edge itself, before the latched
  // copy exists, so the decode looks through to the live inputs while in IDLE.
  logic                    cur_write;
  logic [ADDR_WIDTH-1:0]   cur_addr;
  logic [DATA_WIDTH-1:0]   cur_wdata;
  logic [IDX_W-1:0]        cur_idx;
  logic                    addr_misaligned;
  logic                    addr_in_range;
  logic [1:0]              decode_resp;
  logic                    enter_resp;
  logic                    mem_we;

  always_comb begin
    cur_write = (state_q == StIdle) ? i_write : write_q;
    cur_addr  = (state_q == StIdle) ? i_addr  : addr_q;
    cur_wdata = (state_q == StIdle) ? i_wdata : wdata_q;
  end

  // BASE_ADDR is aligned to the window size, so range membership is an upper-bit compare.
  always_comb begin
    cur_idx         = cur_addr[IDX_W+1:2];
    addr_misaligned = |cur_addr[1:0];
    addr_in_range   = (cur_addr[ADDR_WIDTH-1:IDX_W+2] == BASE_ADDR[ADDR_WIDTH-1:IDX_W+2]);
    if (addr_misaligned) begin
      decode_resp = RESP_ERROR_2;
    end else if (!addr_in_range) begin
      decode_resp = RESP_ERROR_1;
    end else begin
      decode_resp = RESP_SUCCESS;
    end
  end

  // State register (also registers every output).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      resp_q    <= RESP_PENDING;
      rdata_q   <= '0;
      busy_q    <= 1'b0;
      err_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      write_q   <= write_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      resp_q    <= resp_d;
      rdata_q   <= rdata_d;
      busy_q    <= busy_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Memory is not reset; a commit coinciding with rst is dropped.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      mem[cur_idx] <= cur_wdata;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      StIdle: begin
        if (i_trans == TRANS_NONSEQ) begin
          write_d = i_write;
          addr_d  = i_addr;
          wdata_d = i_wdata;
          if (WAIT_CYCLES == 0) begin
            state_d = StResp;
          end else begin
            state_d = StBusy;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      StBusy: begin
        if (cnt_q == 4'd0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Output logic: next values of the registered outputs.
  always_comb begin
    enter_resp = (state_d == StResp) && (state_q != StResp);
    resp_d     = RESP_PENDING;
    rdata_d    = '0;
    busy_d     = (state_d != StIdle);
    err_cnt_d  = err_cnt_q;
    mem_we     = 1'b0;
    if (enter_resp) begin
      resp_d = decode_resp;
      if (decode_resp == RESP_SUCCESS) begin
        if (cur_write) begin
          mem_we = 1'b1;
        end else begin
          rdata_d = mem[cur_idx];
        end
      end else if (err_cnt_q != 8'hFF) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end
    end
  end

  assign o_resp    = resp_q;
  assign o_rdata   = rdata_q;
  assign o_busy    = busy_q;
  assign o_err_cnt = err_cnt_q;

endmodule
